// File: rtl/gcd_stein_param.sv
// gcd_stein_param: binary (Stein) GCD engine with Start/Ack handshake, CEN stepping and a saturating step counter
module gcd_stein_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CEN,
  input  logic             Start,
  input  logic             Ack,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic [WIDTH-1:0] AB_GCD,
  output logic [CNT_W-1:0] Steps,
  output logic             q_I,
  output logic             q_Sub,
  output logic             q_Mult,
  output logic             q_Done
);
  localparam int K_W = $clog2(WIDTH) + 1;
  localparam logic [3:0] S_I = 4'b0001, S_SUB = 4'b0010, S_MULT = 4'b0100, S_DONE = 4'b1000;

  logic [3:0]       state, state_n;
  logic [WIDTH-1:0] a, b;
  logic [K_W-1:0]   i_count;
  logic [CNT_W-1:0] steps_inc;
  logic             zero_op;

  assign zero_op   = (Ain == '0) || (Bin == '0);
  assign steps_inc = &Steps ? Steps : Steps + 1'b1;

  always_ff @(posedge Clk)
    state <= !Reset ? S_I : state_n;

  // illegal encodings fall through to the default and recover to I
  always_comb begin
    state_n = S_I;
    case (state)
      S_I:    state_n = !Start ? S_I : zero_op ? S_DONE : S_SUB;
      S_SUB:  state_n = (CEN && a == b) ? ((i_count == '0) ? S_DONE : S_MULT) : S_SUB;
      S_MULT: state_n = (CEN && i_count == K_W'(1)) ? S_DONE : S_MULT;
      S_DONE: state_n = Ack ? S_I : S_DONE;
      default: state_n = S_I;
    endcase
  end

  always_comb begin
    q_I    = state == S_I;
    q_Sub  = state == S_SUB;
    q_Mult = state == S_MULT;
    q_Done = state == S_DONE;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      a       <= '0;
      b       <= '0;
      AB_GCD  <= '0;
      i_count <= '0;
      Steps   <= '0;
    end else begin
      case (state)
        S_I: begin
          a       <= Ain;
          b       <= Bin;
          i_count <= '0;
          Steps   <= '0;
          AB_GCD  <= (Start && zero_op) ? (Ain | Bin) : '0;
        end
        S_SUB: if (CEN) begin
          Steps <= steps_inc;
          if (a == b) AB_GCD <= a;
          else if (a < b) begin
            a <= b;
            b <= a;
          end else if (!a[0] && !b[0]) begin
            a       <= a >> 1;
            b       <= b >> 1;
            i_count <= i_count + 1'b1;
          end else if (!b[0]) b <= b >> 1;
          else if (!a[0]) a <= a >> 1;
          else a <= a - b;
        end
        S_MULT: if (CEN) begin
          AB_GCD  <= AB_GCD << 1;
          i_count <= i_count - 1'b1;
          Steps   <= steps_inc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_stein_param.sv
// tb_gcd_stein_param: directed checks of the Stein GCD engine at 8-bit and 16-bit (narrow step counter) widths
module tb_gcd_stein_param;
  logic        Clk = 0, Reset = 0;
  logic        cen8 = 0, start8 = 0, ack8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, g8, s8;
  logic        i8, sub8, mult8, done8;
  logic        cen16 = 0, start16 = 0, ack16 = 0;
  logic [15:0] a16 = 0, b16 = 0, g16;
  logic [2:0]  s16;
  logic        i16, sub16, mult16, done16;
  int          vectors = 0, errors = 0;

  always #5 Clk = ~Clk;

  gcd_stein_param d8 (
    .Clk(Clk), .Reset(Reset), .CEN(cen8), .Start(start8), .Ack(ack8), .Ain(a8), .Bin(b8),
    .AB_GCD(g8), .Steps(s8), .q_I(i8), .q_Sub(sub8), .q_Mult(mult8), .q_Done(done8)
  );

  gcd_stein_param #(.WIDTH(16), .CNT_W(3)) d16 (
    .Clk(Clk), .Reset(Reset), .CEN(cen16), .Start(start16), .Ack(ack16), .Ain(a16), .Bin(b16),
    .AB_GCD(g16), .Steps(s16), .q_I(i16), .q_Sub(sub16), .q_Mult(mult16), .q_Done(done16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait8(output int n);
    n = 0;
    while (!done8 && n < 300) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // full handshake on either instance; latency counts edges from Start to q_Done
  task automatic run(input bit w, input logic [15:0] a, input logic [15:0] b, input logic [15:0] eg,
                     input logic [7:0] es, input int elat, input string tag);
    int n;
    if (w) begin a16 = a; b16 = b; start16 = 1; cen16 = 1; end
    else begin a8 = a[7:0]; b8 = b[7:0]; start8 = 1; cen8 = 1; end
    @(negedge Clk);
    start8 = 0;
    start16 = 0;
    n = 1;
    while (!(w ? done16 : done8) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, " done"}, 32'(w ? done16 : done8), 32'd1);
    chk({tag, " gcd"}, w ? 32'(g16) : 32'(g8), 32'(eg));
    chk({tag, " steps"}, w ? 32'(s16) : 32'(s8), 32'(es));
    if (elat > 0) chk({tag, " latency"}, 32'(n), 32'(elat));
    if (w) ack16 = 1; else ack8 = 1;
    @(negedge Clk);
    ack8 = 0;
    ack16 = 0;
    chk({tag, " back_to_I"}, 32'(w ? i16 : i8), 32'd1);
  endtask

  initial begin
    int n, k;
    repeat (2) @(negedge Clk);
    chk("rst q_I8", 32'(i8), 32'd1);
    chk("rst gcd8", 32'(g8), 32'd0);
    chk("rst steps8", 32'(s8), 32'd0);
    chk("rst onehot16", 32'({done16, mult16, sub16, i16}), 32'b0001);
    Reset = 1;
    @(negedge Clk);

    run(0, 36, 24, 12, 8, 9, "g36_24");
    run(0, 0, 9, 9, 0, 1, "g0_9");
    run(0, 0, 0, 0, 0, 1, "g0_0");
    run(0, 9, 0, 9, 0, 1, "g9_0");
    run(0, 7, 7, 7, 1, 2, "g7_7");
    run(1, 16'h8000, 16'h8000, 16'h8000, 1, 2, "w16_8000");
    run(1, 16'hFFFF, 16'h8000, 16'h0001, 7, 0, "w16_ffff");
    run(1, 36, 24, 12, 7, 9, "w16_sat");

    // CEN toggling: Steps must track only CEN=1 edges
    a8 = 12; b8 = 18; start8 = 1; cen8 = 0;
    @(negedge Clk);
    start8 = 0;
    chk("cen sub_without_cen", 32'(sub8), 32'd1);
    k = 0;
    while (!done8 && k < 40) begin
      cen8 = 1;
      @(negedge Clk);
      k++;
      if (done8) break;
      cen8 = 0;
      @(negedge Clk);
      chk("cen hold_steps", 32'(s8), 32'(k));
    end
    chk("cen done", 32'(done8), 32'd1);
    chk("cen gcd", 32'(g8), 32'd6);
    chk("cen steps", 32'(s8), 32'd7);
    ack8 = 1;
    @(negedge Clk);
    ack8 = 0;
    cen8 = 1;

    // reset mid-SUB
    a8 = 200; b8 = 150; start8 = 1;
    @(negedge Clk);
    start8 = 0;
    repeat (2) @(negedge Clk);
    chk("mid steps_before", 32'(s8), 32'd2);
    Reset = 0;
    @(negedge Clk);
    chk("mid q_I", 32'(i8), 32'd1);
    chk("mid gcd", 32'(g8), 32'd0);
    chk("mid steps", 32'(s8), 32'd0);
    Reset = 1;
    @(negedge Clk);
    run(0, 200, 150, 50, 8, 9, "g200_150");

    // Start and Ack both held: DONE -> I -> SUB restart loop
    a8 = 36; b8 = 24; start8 = 1; ack8 = 1;
    @(negedge Clk);
    chk("loop sub", 32'(sub8), 32'd1);
    wait8(n);
    chk("loop done", 32'(done8), 32'd1);
    @(negedge Clk);
    chk("loop I", 32'(i8), 32'd1);
    @(negedge Clk);
    chk("loop resub", 32'(sub8), 32'd1);
    start8 = 0;
    ack8 = 0;
    wait8(n);
    chk("loop gcd", 32'(g8), 32'd12);
    start8 = 1;
    @(negedge Clk);
    chk("start_in_done stays", 32'(done8), 32'd1);
    chk("start_in_done gcd", 32'(g8), 32'd12);
    chk("start_in_done steps", 32'(s8), 32'd8);
    start8 = 0;
    ack8 = 1;
    @(negedge Clk);
    ack8 = 0;
    chk("final I", 32'(i8), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
